// File: rtl/tumble_run_checker.sv
// ============================================================================
// Module   : tumble_run_checker
// Summary  : Launches a Turing Tumble puzzle run, waits for it to stop, then
//            scans the collected tray against an expected ball pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tumble_run_checker #(
    parameter logic [19:0] EXPECT_BITS = 20'h00000,
    parameter logic [4:0]  EXPECT_SIZE = 5'd0,
    parameter int          START_LEN   = 2,
    parameter logic [15:0] TIMEOUT     = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        start,
    input  logic        stopped,
    input  logic [19:0] tray,
    input  logic [4:0]  tray_size,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [4:0]  red_count,
    output logic [4:0]  blue_count,
    output logic [4:0]  mismatch_idx
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_SCAN      = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    localparam logic [3:0]  C_START_LAST  = 4'(START_LEN - 1);
    localparam logic [15:0] C_TO_LAST     = TIMEOUT - 16'd1;
    localparam logic [4:0]  C_NO_MISMATCH = 5'd31;
    localparam logic [4:0]  C_SCAN_LAST   = 5'd19;
    localparam logic [4:0]  C_TRAY_MAX    = 5'd20;

    state_t      state_q, state_d;
    logic        stp_meta_q, stp_meta_d;
    logic        stp_s_q, stp_s_d;
    logic [3:0]  start_cnt_q, start_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [19:0] tray_sh_q, tray_sh_d;
    logic [4:0]  size_sh_q, size_sh_d;
    logic        oversize_q, oversize_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timed_out_q, timed_out_d;
    logic [4:0]  red_q, red_d;
    logic [4:0]  blue_q, blue_d;
    logic [4:0]  mism_q, mism_d;

    logic [4:0]  w_limit;
    logic        w_mism_hit;

    assign w_limit    = (size_sh_q > EXPECT_SIZE) ? size_sh_q : EXPECT_SIZE;
    assign w_mism_hit = (idx_q < w_limit) &&
                        ((idx_q >= size_sh_q) || (idx_q >= EXPECT_SIZE) ||
                         (tray_sh_q[idx_q] != EXPECT_BITS[idx_q]));

    always_comb begin
        state_d     = state_q;
        stp_meta_d  = stopped;
        stp_s_d     = stp_meta_q;
        start_cnt_d = start_cnt_q;
        to_cnt_d    = to_cnt_q;
        idx_d       = idx_q;
        tray_sh_d   = tray_sh_q;
        size_sh_d   = size_sh_q;
        oversize_d  = oversize_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        red_d       = red_q;
        blue_d      = blue_q;
        mism_d      = mism_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    pass_d      = 1'b0;
                    timed_out_d = 1'b0;
                    red_d       = 5'd0;
                    blue_d      = 5'd0;
                    mism_d      = C_NO_MISMATCH;
                    start_cnt_d = 4'd0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (start_cnt_q == C_START_LAST) begin
                    to_cnt_d = 16'd0;
                    state_d  = S_WAIT_LOW;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            S_WAIT_LOW, S_WAIT_HIGH: begin
                if (to_cnt_q == C_TO_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    if (state_q == S_WAIT_LOW) begin
                        if (!stp_s_q) state_d = S_WAIT_HIGH;
                    end else if (stp_s_q) begin
                        // Tray is frozen here; the scan never looks at the live inputs.
                        tray_sh_d  = tray;
                        oversize_d = (tray_size > C_TRAY_MAX);
                        size_sh_d  = (tray_size > C_TRAY_MAX) ? C_TRAY_MAX : tray_size;
                        idx_d      = 5'd0;
                        state_d    = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (idx_q < size_sh_q) begin
                    if (tray_sh_q[idx_q]) red_d  = red_q + 5'd1;
                    else                  blue_d = blue_q + 5'd1;
                end
                if ((mism_q == C_NO_MISMATCH) && w_mism_hit) mism_d = idx_q;
                if (idx_q == C_SCAN_LAST) begin
                    if (oversize_q && (mism_d == C_NO_MISMATCH)) mism_d = C_TRAY_MAX;
                    state_d = S_REPORT;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_REPORT: begin
                pass_d  = !timed_out_q && (size_sh_q == EXPECT_SIZE) &&
                          (mism_q == C_NO_MISMATCH);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stp_meta_q  <= 1'b0;
            stp_s_q     <= 1'b0;
            start_cnt_q <= 4'd0;
            to_cnt_q    <= 16'd0;
            idx_q       <= 5'd0;
            tray_sh_q   <= 20'd0;
            size_sh_q   <= 5'd0;
            oversize_q  <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            red_q       <= 5'd0;
            blue_q      <= 5'd0;
            mism_q      <= C_NO_MISMATCH;
        end else begin
            state_q     <= state_d;
            stp_meta_q  <= stp_meta_d;
            stp_s_q     <= stp_s_d;
            start_cnt_q <= start_cnt_d;
            to_cnt_q    <= to_cnt_d;
            idx_q       <= idx_d;
            tray_sh_q   <= tray_sh_d;
            size_sh_q   <= size_sh_d;
            oversize_q  <= oversize_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            red_q       <= red_d;
            blue_q      <= blue_d;
            mism_q      <= mism_d;
        end
    end

    assign start        = start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timed_out    = timed_out_q;
    assign red_count    = red_q;
    assign blue_count   = blue_q;
    assign mismatch_idx = mism_q;

endmodule

`default_nettype wire

// File: tb/tb_tumble_run_checker.sv
// ============================================================================
// Module   : tb_tumble_run_checker
// Summary  : Directed vector bench for tumble_run_checker with a scripted
//            puzzle model driving stopped/tray/tray_size.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tumble_run_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        start;
    logic        stopped;
    logic [19:0] tray;
    logic [4:0]  tray_size;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [4:0]  red_count;
    logic [4:0]  blue_count;
    logic [4:0]  mismatch_idx;

    always #5 clk = ~clk;

    tumble_run_checker #(
        .EXPECT_BITS (20'h002AA),
        .EXPECT_SIZE (5'd10),
        .START_LEN   (2),
        .TIMEOUT     (16'd100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .start        (start),
        .stopped      (stopped),
        .tray         (tray),
        .tray_size    (tray_size),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timed_out    (timed_out),
        .red_count    (red_count),
        .blue_count   (blue_count),
        .mismatch_idx (mismatch_idx)
    );

    typedef struct {
        logic [19:0] tray;
        logic [4:0]  size;
        logic        pass;
        logic [4:0]  red;
        logic [4:0]  blue;
        logic [4:0]  mism;
    } vec_t;

    vec_t vecs [9];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    // One-cycle run request, then check the START_LEN=2 pulse shape.
    task automatic launch();
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("start_rise", start, 1);
        chk("busy_rise", busy, 1);
        tick();
        chk("start_hold", start, 1);
        tick();
        chk("start_fall", start, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        stopped = 1'b1;
        launch();
        stopped = 1'b0;
        repeat (50) tick();
        tray      = v.tray;
        tray_size = v.size;
        stopped   = 1'b1;
        // 3 cycles of sync + FSM, 20 scan steps, 1 report
        wait_done(40, k);
        chk({tag, "_done_lat"}, k, 24);
        chk({tag, "_pass"}, pass, v.pass);
        chk({tag, "_timeout"}, timed_out, 0);
        chk({tag, "_red"}, red_count, v.red);
        chk({tag, "_blue"}, blue_count, v.blue);
        chk({tag, "_mism"}, mismatch_idx, v.mism);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_red_hold"}, red_count, v.red);
    endtask

    initial begin
        int k;
        int hi;

        vecs[0] = '{20'h002AA, 5'd10, 1'b1, 5'd5,  5'd5,  5'd31};
        vecs[1] = '{20'h002AB, 5'd10, 1'b0, 5'd6,  5'd4,  5'd0};
        vecs[2] = '{20'h00AAA, 5'd12, 1'b0, 5'd6,  5'd6,  5'd10};
        vecs[3] = '{20'h002AA, 5'd8,  1'b0, 5'd4,  5'd4,  5'd8};
        vecs[4] = '{20'h002AA, 5'd25, 1'b0, 5'd5,  5'd15, 5'd10};
        vecs[5] = '{20'h002AA, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0};
        vecs[6] = '{20'h000AA, 5'd10, 1'b0, 5'd4,  5'd6,  5'd9};
        vecs[7] = '{20'hFFEAA, 5'd10, 1'b1, 5'd5,  5'd5,  5'd31};
        vecs[8] = '{20'hFFFFF, 5'd20, 1'b0, 5'd20, 5'd0,  5'd0};

        rst = 1'b1; run = 1'b0; stopped = 1'b1; tray = 20'd0; tray_size = 5'd0;
        repeat (3) tick();
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timed_out, 0);
        chk("rst_red", red_count, 0);
        chk("rst_blue", blue_count, 0);
        chk("rst_mism", mismatch_idx, 31);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Timeout: stopped drops and never comes back.
        stopped = 1'b1;
        launch();
        stopped = 1'b0;
        wait_done(120, k);
        chk("to_done_lat", k + 2, 103);
        chk("to_flag", timed_out, 1);
        chk("to_pass", pass, 0);
        chk("to_mism", mismatch_idx, 31);

        // Reset while scanning index 7.
        stopped = 1'b1;
        launch();
        stopped = 1'b0;
        repeat (10) tick();
        tray = 20'h002AA; tray_size = 5'd10; stopped = 1'b1;
        repeat (10) tick();
        chk("mid_red", red_count, 3);
        chk("mid_blue", blue_count, 4);
        rst = 1'b1;
        #1;
        chk("mrst_start", start, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_pass", pass, 0);
        chk("mrst_red", red_count, 0);
        chk("mrst_blue", blue_count, 0);
        chk("mrst_mism", mismatch_idx, 31);
        tick();
        rst = 1'b0;
        tick();
        run_vec(vecs[0], "post_rst");

        // run held high across a whole check.
        stopped = 1'b1;
        run = 1'b1;
        hi = 0;
        k = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (start === 1'b1) hi++;
            if (i == 4) stopped = 1'b0;
            if (i == 30) begin
                tray = 20'h002AA; tray_size = 5'd10; stopped = 1'b1;
            end
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("bg_done_at", k, 54);
        chk("bg_start_cycles", hi, 2);
        chk("bg_pass", pass, 1);
        chk("bg_no_start_at_done", start, 0);
        tick();
        chk("bg_restart", start, 1);
        chk("bg_restart_busy", busy, 1);
        rst = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
